adc_frame_rx: RTL and testbench
===============================

Name: adc_frame_rx

Overview:
Parametrised synchronous receiver for the nibble-serial frame sent by the ADC/controller front end. It synchronises the asynchronous adc_int strobe into the system clock and captures one data word per strobe into a shadow buffer. A complete frame is committed atomically to the output bus. Adds word-count and frame-timeout resynchronisation, and an optional checksum. Sits between the ADC interface pins and the display/temperature-control logic.

Parameters:
DATA_W, 4, width of one transferred word.
NUM_WORDS, 7, payload words per frame (default map: digit lo/hi, current_temp lo/hi, set_temp lo/hi, set_time).
TIMEOUT_CYC, 1000, clk cycles without a strobe mid-frame before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
adc_int  in  1  asynchronous word strobe; rising edge marks a valid word.
data  in  DATA_W  word bus; stable from adc_int rise until at least 4 clk cycles later.
frame_data  out  NUM_WORDS*DATA_W  committed frame; word k at [k*DATA_W +: DATA_W].
frame_valid  out  1  one-cycle pulse after each commit.
word_idx  out  clog2(NUM_WORDS+1)  index of the next expected word.
busy  out  1  high while word_idx != 0.
timeout_err  out  1  one-cycle pulse on frame abort by timeout.
chk_err  out  1  one-cycle pulse on checksum mismatch; constant 0 without the optional feature.

Behaviour:
- Reset (rst_n low, async): all outputs 0, shadow buffer 0, sync flops 0, timeout counter 0.
- adc_int passes through 3 flops s1→s2→s3. edge = s2 & ~s3.
- On a clk edge with edge=1: shadow[word_idx] <= data, word_idx increments, timeout counter clears.
- Last word (word_idx == LAST, where LAST = NUM_WORDS-1, or NUM_WORDS with checksum): word_idx <= 0.
  - frame_data is loaded on the same edge with the shadow words plus the incoming word.
  - frame_valid is high for the following cycle only.
- Latency: frame_valid asserts 3–4 clk after the final adc_int rise, depending on strobe phase.
- Partial frames never alter frame_data. frame_data holds its value until the next commit.
- Timeout: while busy and edge=0, the counter increments.
  - When the counter reaches TIMEOUT_CYC-1, word_idx <= 0 and the counter clears.
  - timeout_err pulses 1 cycle and the shadow is discarded.
  - edge and timeout expiry on the same cycle: the edge wins, with no error and the word accepted.
  - The counter is idle (held at 0) when not busy.
- A strobe pulse shorter than 2 clk may be missed. This is not detected; the timeout recovers.
- Successive strobes need an adc_int low time of ≥2 clk.
- Reset mid-frame: shadow and index are cleared; frame_data returns to 0.
- A single state machine covers both idle (word_idx=0) and receiving (word_idx>0). No other states.

Optional Feature:
Macro FRAME_CHECKSUM_EN.
- Defined: the frame carries one extra word (index NUM_WORDS) equal to the sum of the NUM_WORDS payload words mod 2^DATA_W.
  - Match: commit and frame_valid as above.
  - Mismatch: no commit, frame_data unchanged, chk_err pulses 1 cycle in place of frame_valid, word_idx <= 0.
  - The checksum word is not stored in frame_data.
- Undefined: frame is NUM_WORDS words, chk_err tied 0, no adder logic.

Test Plan:
- Reset then 7 strobes with data 1,2,3,4,5,6,7 (≥6 clk spacing) -> frame_data=0x7654321, one frame_valid pulse, word_idx back to 0.
- 3 strobes then silence TIMEOUT_CYC cycles -> timeout_err pulse at cycle TIMEOUT_CYC after the last capture, frame_data unchanged. A following full frame of 0xA words commits 0xAAAAAAA.
- Strobe arriving exactly on the timeout expiry cycle -> word accepted, no timeout_err, word_idx increments.
- rst_n low asynchronously after 4 words, then release and 7 words of 0xF -> outputs 0 during reset, then frame_data=0xFFFFFFF.
- FRAME_CHECKSUM_EN, payload 1..7 with checksum 0xC -> commit. Same payload with checksum 0xB -> chk_err pulse, no frame_valid, frame_data keeps its prior value.
- Back-to-back frames with minimum 2-clk high/low strobes -> every word captured, two frame_valid pulses, correct second frame.

Source files
------------

// File: rtl/adc_frame_rx.sv
// Nibble-serial ADC frame receiver: synchronises adc_int, captures one word per strobe and commits whole frames.
// Optional trailing checksum word enabled by defining FRAME_CHECKSUM_EN.
module adc_frame_rx #(
    parameter int DATA_W      = 4,
    parameter int NUM_WORDS   = 7,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            adc_int,
    input  logic [DATA_W-1:0]               data,
    output logic [NUM_WORDS*DATA_W-1:0]     frame_data,
    output logic                            frame_valid,
    output logic [$clog2(NUM_WORDS+1)-1:0]  word_idx,
    output logic                            busy,
    output logic                            timeout_err,
    output logic                            chk_err
);

    localparam int IDX_W = $clog2(NUM_WORDS+1);
`ifdef FRAME_CHECKSUM_EN
    localparam int LAST = NUM_WORDS;
`else
    localparam int LAST = NUM_WORDS - 1;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

    localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

    // The FSM state is fully encoded by word_idx; busy exposes it.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [0:0]                      state;
    logic                            s1, s2, s3;
    logic                            strobe_edge;
    logic [NUM_WORDS*DATA_W-1:0]     shadow;
    logic [NUM_WORDS*DATA_W-1:0]     shadow_next;
    logic [CNT_W-1:0]                to_cnt;
    logic                            is_last;
    logic                            timeout_hit;
    logic                            chk_ok;

    assign state       = (word_idx != '0) ? ST_RECV : ST_IDLE;
    assign busy        = (state == ST_RECV);
    assign strobe_edge = s2 & ~s3;
    assign is_last     = (word_idx == LAST_IDX);
    assign timeout_hit = (TIMEOUT_CYC != 0) && busy && !strobe_edge && (to_cnt == TO_LAST_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= adc_int;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Shadow image with the incoming word merged in, used both to capture and to commit.
    always_comb begin
        shadow_next = shadow;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (word_idx == IDX_W'(k)) begin
                shadow_next[k*DATA_W +: DATA_W] = data;
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] chk_sum;

    always_comb begin
        chk_sum = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            chk_sum = chk_sum + shadow[k*DATA_W +: DATA_W];
        end
    end

    assign chk_ok = (chk_sum == data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else begin
            chk_err <= strobe_edge && is_last && !chk_ok;
        end
    end
`else
    assign chk_ok  = 1'b1;
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx    <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
        end else begin
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            if (strobe_edge) begin
                // A strobe always wins over a coincident timeout expiry.
                to_cnt <= '0;
                if (is_last) begin
                    word_idx <= '0;
                    shadow   <= '0;
                    if (chk_ok) begin
                        frame_data  <= shadow_next;
                        frame_valid <= 1'b1;
                    end
                end else begin
                    word_idx <= word_idx + IDX_W'(1);
                    shadow   <= shadow_next;
                end
            end else if (busy) begin
                if (timeout_hit) begin
                    word_idx    <= '0;
                    shadow      <= '0;
                    to_cnt      <= '0;
                    timeout_err <= 1'b1;
                end else if (TIMEOUT_CYC != 0) begin
                    to_cnt <= to_cnt + CNT_W'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_rx.sv
// Self-checking bench for adc_frame_rx: vector table of frames plus timeout, reset, checksum and back-to-back sequences.
module tb_adc_frame_rx;

    localparam int TO = 64;

    logic        clk;
    logic        rst_n;
    logic        adc_int;
    logic [3:0]  data;
    logic [27:0] frame_data;
    logic        frame_valid;
    logic [2:0]  word_idx;
    logic        busy;
    logic        timeout_err;
    logic        chk_err;

    adc_frame_rx #(.DATA_W(4), .NUM_WORDS(7), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc_int     (adc_int),
        .data        (data),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .word_idx    (word_idx),
        .busy        (busy),
        .timeout_err (timeout_err),
        .chk_err     (chk_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1);
    end

    // scoreboard
    logic [27:0] exp_q[$];
    logic [27:0] exp_frame;
    int tests = 0;
    int fails = 0;
    int fv_cnt = 0;
    int te_cnt = 0;
    int ce_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) begin
                fv_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_commit: frame_data=0x%0h, expected no commit", frame_data);
                end else begin
                    exp_frame = exp_q.pop_front();
                    check("frame_data", {36'd0, frame_data}, {36'd0, exp_frame});
                end
            end
            if (timeout_err) te_cnt++;
            if (chk_err) ce_cnt++;
        end
    end

    // drivers
    task automatic send_word(input logic [3:0] d, input int hi, input int lo);
        @(negedge clk);
        data    = d;
        adc_int = 1'b1;
        repeat (hi) @(negedge clk);
        adc_int = 1'b0;
        repeat (lo - 1) @(negedge clk);
    endtask

`ifdef FRAME_CHECKSUM_EN
    function automatic logic [3:0] csum(input logic [3:0] w[7]);
        logic [3:0] s;
        s = 4'h0;
        for (int i = 0; i < 7; i++) s = s + w[i];
        return s;
    endfunction
`endif

    // Sends w[start..6] (plus checksum word when enabled); the expected commit is queued before the final word.
    task automatic send_frame(input logic [3:0] w[7], input int start, input logic [27:0] exp,
                              input int hi, input int lo, input bit bad_chk);
`ifdef FRAME_CHECKSUM_EN
        logic [3:0] cs;
        for (int i = start; i < 7; i++) send_word(w[i], hi, lo);
        cs = csum(w);
        if (bad_chk) cs = cs - 4'h1;
        if (!bad_chk) exp_q.push_back(exp);
        send_word(cs, hi, lo);
`else
        for (int i = start; i < 7; i++) begin
            if (i == 6 && !bad_chk) exp_q.push_back(exp);
            send_word(w[i], hi, lo);
        end
`endif
    endtask

    task automatic rise_and_wait(input logic [3:0] d, input logic [2:0] target, output bit ok);
        @(negedge clk);
        data    = d;
        adc_int = 1'b1;
        ok      = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 2) adc_int = 1'b0;
            if (word_idx == target) begin
                ok = 1'b1;
                break;
            end
        end
        adc_int = 1'b0;
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  w[7];
        logic [27:0] exp;
        int          hi;
        int          lo;
    } vec_t;

    vec_t        vecs[4];
    logic [3:0]  wa[7];
    logic [3:0]  wb[7];
    logic [3:0]  wf[7];
    logic [3:0]  w5[7];
    int          fv0, te0, ce0, n;
    bit          ok;

    initial begin
        vecs[0] = '{'{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7}, 28'h7654321, 3, 3};
        vecs[1] = '{'{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA}, 28'hAAAAAAA, 4, 2};
        vecs[2] = '{'{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0}, 28'h0F0F0F0, 2, 4};
        vecs[3] = '{'{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3}, 28'h3456789, 3, 3};
        wa = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        wb = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        wf = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        w5 = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5};

        adc_int = 1'b0;
        data    = 4'h0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_frame_data", {36'd0, frame_data}, 64'd0);
        check("rst_frame_valid", {63'd0, frame_valid}, 64'd0);
        check("rst_word_idx", {61'd0, word_idx}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
        check("rst_chk_err", {63'd0, chk_err}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // vector table
        for (int i = 0; i < 4; i++) begin
            fv0 = fv_cnt;
            send_frame(vecs[i].w, 0, vecs[i].exp, vecs[i].hi, vecs[i].lo, 1'b0);
            settle();
            check("vec_commits", 64'(fv_cnt - fv0), 64'd1);
            check("vec_word_idx", {61'd0, word_idx}, 64'd0);
            check("vec_pending", 64'(exp_q.size()), 64'd0);
        end

        // timeout after 3 words, then a full frame
        te0 = te_cnt;
        send_word(4'h1, 3, 3);
        send_word(4'h2, 3, 3);
        rise_and_wait(4'h3, 3'd3, ok);
        check("to_capture_seen", {63'd0, ok}, 64'd1);
        n = 0;
        for (int c = 1; c <= 2 * TO; c++) begin
            @(negedge clk);
            if (timeout_err) begin
                n = c;
                break;
            end
        end
        check("to_cycle", 64'(n), 64'(TO));
        @(negedge clk);
        check("to_err_pulse_width", {63'd0, timeout_err}, 64'd0);
        check("to_word_idx", {61'd0, word_idx}, 64'd0);
        check("to_frame_kept", {36'd0, frame_data}, 64'h3456789);
        check("to_err_count", 64'(te_cnt - te0), 64'd1);
        fv0 = fv_cnt;
        send_frame(vecs[1].w, 0, 28'hAAAAAAA, 3, 3, 1'b0);
        settle();
        check("to_next_commit", 64'(fv_cnt - fv0), 64'd1);

        // strobe landing exactly on the expiry cycle
        te0 = te_cnt;
        send_word(4'h1, 3, 3);
        send_word(4'h2, 3, 3);
        rise_and_wait(4'h3, 3'd3, ok);
        check("exp_capture_seen", {63'd0, ok}, 64'd1);
        repeat (TO - 3) @(negedge clk);
        data    = 4'h4;
        adc_int = 1'b1;
        repeat (2) @(negedge clk);
        adc_int = 1'b0;
        repeat (3) @(negedge clk);
        check("exp_word_idx", {61'd0, word_idx}, 64'd4);
        check("exp_no_timeout", 64'(te_cnt - te0), 64'd0);
        send_frame(wa, 4, 28'h7654321, 3, 3, 1'b0);
        settle();
        check("exp_pending", 64'(exp_q.size()), 64'd0);

        // asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) send_word(w5[i], 3, 3);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_frame_data", {36'd0, frame_data}, 64'd0);
        check("mid_rst_word_idx", {61'd0, word_idx}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(wf, 0, 28'hFFFFFFF, 3, 3, 1'b0);
        settle();
        check("post_rst_frame", {36'd0, frame_data}, 64'hFFFFFFF);

`ifdef FRAME_CHECKSUM_EN
        ce0 = ce_cnt;
        fv0 = fv_cnt;
        send_frame(wa, 0, 28'h7654321, 3, 3, 1'b1);
        settle();
        check("chk_bad_err", 64'(ce_cnt - ce0), 64'd1);
        check("chk_bad_no_commit", 64'(fv_cnt - fv0), 64'd0);
        check("chk_bad_frame_kept", {36'd0, frame_data}, 64'hFFFFFFF);
        send_frame(wa, 0, 28'h7654321, 3, 3, 1'b0);
        settle();
        check("chk_good_commit", 64'(fv_cnt - fv0), 64'd1);
        check("chk_good_no_err", 64'(ce_cnt - ce0), 64'd1);
`endif

        // back-to-back frames at minimum strobe timing
        fv0 = fv_cnt;
        send_frame(wa, 0, 28'h7654321, 2, 2, 1'b0);
        send_frame(wb, 0, 28'hEDCBA98, 2, 2, 1'b0);
        settle();
        check("b2b_commits", 64'(fv_cnt - fv0), 64'd2);
        check("b2b_frame", {36'd0, frame_data}, 64'hEDCBA98);
        check("b2b_word_idx", {61'd0, word_idx}, 64'd0);
        check("b2b_pending", 64'(exp_q.size()), 64'd0);

`ifndef FRAME_CHECKSUM_EN
        ce0 = 0;
        check("chk_err_never", 64'(ce_cnt - ce0), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
